// File: rtl/weightmem_ctrl_pkg.sv
// Shared types and default geometry for the weight-memory controller.
package weightmem_ctrl_pkg;

    localparam int N_I             = 64;
    localparam int WEIGHT_STAGGER  = 8;
    localparam int WEIGHTBANKDEPTH = 16;
    // Physical bits per stored weight word.
    localparam int WEIGHT_WORD_BITS = ((N_I / WEIGHT_STAGGER + 4) / 5) * 5 / 5 * 8;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } weightmem_ctrl_state_e;

endpackage

// File: rtl/weightmem_ctrl_if.sv
// Host write, burst request, read stream and SRAM bank signals of the controller.
interface weightmem_ctrl_if
    import weightmem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = $clog2(WEIGHTBANKDEPTH),
    parameter int DATA_WIDTH = WEIGHT_WORD_BITS,
    parameter int LEN_WIDTH  = $clog2(WEIGHTBANKDEPTH) + 1
);
    logic                  wr_req_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  wr_gnt_o;

    logic                  burst_valid_i;
    logic [ADDR_WIDTH-1:0] burst_addr_i;
    logic [LEN_WIDTH-1:0]  burst_len_i;
    logic                  burst_ready_o;

    logic                  rd_valid_o;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_last_o;
    logic                  rd_ready_i;
    logic                  done_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_be_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output wr_req_i, wr_addr_i, wr_data_i,
        output burst_valid_i, burst_addr_i, burst_len_i,
        output rd_ready_i, mem_rdata_i,
        input  wr_gnt_o, burst_ready_o, rd_valid_o, rd_data_o, rd_last_o, done_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

    modport slave (
        input  wr_req_i, wr_addr_i, wr_data_i,
        input  burst_valid_i, burst_addr_i, burst_len_i,
        input  rd_ready_i, mem_rdata_i,
        output wr_gnt_o, burst_ready_o, rd_valid_o, rd_data_o, rd_last_o, done_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
    );

endinterface

// File: rtl/weightmem_rd_fifo.sv
// Two-entry read-data FIFO; push and pop take effect at the clock edge, head is visible at once.
// Caller guarantees no push when full and no pop when empty; simultaneous push/pop are both honoured.
module weightmem_rd_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] slot [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= push_dat;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Empty FIFO presents zeros so stale words never leak onto the stream.
    assign head_dat = (cnt != 2'd0) ? slot[rd_ptr] : '0;

endmodule

// File: rtl/weightmem_ctrl.sv
// Arbitrates one single-port weight bank between host writes and burst reads; burst words stream out
// via a 2-entry FIFO, first word valid three cycles after acceptance, issue stalls under backpressure.
module weightmem_ctrl
    import weightmem_ctrl_pkg::*;
#(
    parameter int NUM_WORDS  = WEIGHTBANKDEPTH,
    parameter int DATA_WIDTH = WEIGHT_WORD_BITS,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS),
    parameter int LEN_WIDTH  = $clog2(NUM_WORDS) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    weightmem_ctrl_if.slave bus
);

    weightmem_ctrl_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic                  wr_gnt;
    logic                  burst_ready;
    logic                  accept;
    logic                  issue;
    logic                  done;
    logic                  pop;
    logic                  room;
    logic [2:0]            occ;
    logic                  final_issue;
    logic [ADDR_WIDTH-1:0] addr_next;

    logic [1:0]            fifo_cnt;
    logic [DATA_WIDTH:0]   fifo_head;

    assign pop         = bus.rd_valid_o & bus.rd_ready_i;
    // Words already buffered or on their way, minus the one leaving this cycle.
    assign occ         = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign room        = (occ < 3'd2);
    assign final_issue = (rem_q == LEN_WIDTH'(1));
    assign addr_next   = (addr_q == ADDR_WIDTH'(NUM_WORDS - 1)) ? '0 : addr_q + 1'b1;
    assign accept      = burst_ready & bus.burst_valid_i;

    always_comb begin
        state_d     = state_q;
        wr_gnt      = 1'b0;
        burst_ready = 1'b0;
        issue       = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wr_req_i) begin
                    wr_gnt = 1'b1;
                end else begin
                    burst_ready = 1'b1;
                end
            end
            READ: begin
                if (room) begin
                    issue = 1'b1;
                    if (final_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Completion cycle already behaves as idle towards the burst port.
                if (fifo_cnt == 2'd0 && !inflight_q) begin
                    done        = 1'b1;
                    state_d     = IDLE;
                    burst_ready = ~bus.wr_req_i;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = (bus.burst_len_i == '0) ? DRAIN : READ;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= issue;
            inflight_last_q <= issue & final_issue;
            if (accept) begin
                addr_q <= bus.burst_addr_i;
                rem_q  <= bus.burst_len_i;
            end else if (issue) begin
                addr_q <= addr_next;
                rem_q  <= rem_q - LEN_WIDTH'(1);
            end
        end
    end

    weightmem_rd_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (inflight_q),
        .push_dat({inflight_last_q, bus.mem_rdata_i}),
        .pop     (pop),
        .head_dat(fifo_head),
        .cnt     (fifo_cnt)
    );

    assign bus.wr_gnt_o      = wr_gnt;
    assign bus.burst_ready_o = burst_ready;
    assign bus.done_o        = done;
    assign bus.rd_valid_o    = (fifo_cnt != 2'd0);
    assign bus.rd_last_o     = fifo_head[DATA_WIDTH];
    assign bus.rd_data_o     = fifo_head[DATA_WIDTH-1:0];

    assign bus.mem_req_o   = wr_gnt | issue;
    assign bus.mem_we_o    = wr_gnt;
    assign bus.mem_addr_o  = wr_gnt ? bus.wr_addr_i : (issue ? addr_q : '0);
    assign bus.mem_wdata_o = wr_gnt ? bus.wr_data_i : '0;
    assign bus.mem_be_o    = '1;

endmodule

// File: doc/weightmem_ctrl.md
# weightmem_ctrl

Sequencer and arbiter in front of one `sram_weightmem` bank. It shares the single-port bank between the host programming path (word writes) and the compute-side weight loader, which issues bursts of reads. Each burst runs as back-to-back SRAM reads, absorbs the one-cycle SRAM read latency, and delivers words on a valid/ready stream with backpressure through a 2-entry output FIFO.

## Interface
- `NUM_WORDS`, default `cutie_params::WEIGHTBANKDEPTH`: bank depth in words.
- `DATA_WIDTH`, default physical bits per weight word (`((N_I/WEIGHT_STAGGER+4)/5)*5/5*8`): word width.
- `ADDR_WIDTH`, default `$clog2(NUM_WORDS)`: address width.
- `LEN_WIDTH`, default `$clog2(NUM_WORDS)+1`: burst length width.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `wr_req_i` in 1: host write request.
- `wr_addr_i` in ADDR_WIDTH: host write address.
- `wr_data_i` in DATA_WIDTH: host write data.
- `wr_gnt_o` out 1: write accepted this cycle.
- `burst_valid_i` in 1: burst request.
- `burst_addr_i` in ADDR_WIDTH: burst start address.
- `burst_len_i` in LEN_WIDTH: burst word count.
- `burst_ready_o` out 1: burst accepted when high together with `burst_valid_i`.
- `rd_valid_o` out 1: output stream valid.
- `rd_data_o` out DATA_WIDTH: output stream data.
- `rd_last_o` out 1: marks the final word of a burst.
- `rd_ready_i` in 1: stream consumer ready.
- `done_o` out 1: one-cycle pulse when a burst completes.
- `mem_req_o`, `mem_we_o` out 1: SRAM request and write enable.
- `mem_addr_o` out ADDR_WIDTH: SRAM address.
- `mem_wdata_o`, `mem_be_o` out DATA_WIDTH: SRAM write data and byte enable; `mem_be_o` is constant all-ones.
- `mem_rdata_i` in DATA_WIDTH: SRAM read data, valid the cycle after a read request.

## Operation
- States:
  - IDLE: no burst in progress.
  - READ: read addresses remaining to issue.
  - DRAIN: all addresses issued, waiting for in-flight data and FIFO to empty.
- **IDLE arbitration:**
  - `wr_req_i` high: drive an SRAM write (req=1, we=1) combinationally from `wr_*` and assert `wr_gnt_o`. `burst_ready_o` = 0.
  - Otherwise `burst_ready_o` = 1. On handshake, latch address and remaining length; enter READ, or DRAIN if length is 0.
  - Writes win over bursts. Writes are never granted outside IDLE.
- **READ issue rule:** issue a read when `fifo_cnt + inflight - pop < 2`, where `pop = rd_valid_o & rd_ready_i`.
  - On each issue, the address increments and wraps from NUM_WORDS-1 to 0. Remaining length decrements.
  - After the final issue, go to DRAIN.
- **inflight** is 1 in the cycle after a read issue. That cycle `mem_rdata_i` is pushed into the FIFO, tagged last if it was the burst's final address.
- **DRAIN:** when FIFO is empty and inflight = 0, pulse `done_o` and return to IDLE in the same cycle.
- **Stream:** FIFO head drives `rd_data_o` and `rd_last_o`; `rd_valid_o` = FIFO not empty. Data and last are held stable while valid is high and ready is low.
- **FIFO:** never overflows by construction. A push and a pop in the same cycle are both honoured.

## Timing
- **Reset values:**
  - All control outputs 0, `rd_data_o` 0, state IDLE, FIFO empty, inflight 0.
  - Exceptions: `burst_ready_o` = 1 when `wr_req_i` = 0; `mem_be_o` is all-ones.
- **Burst accepted at cycle T, `rd_ready_i` held high:**
  - first `mem_req_o` at T+1; data pushed at T+2; `rd_valid_o` from T+3.
  - One word per cycle; last word at T+2+N; `done_o` at T+3+N; `burst_ready_o` high again at T+3+N.
- **Length-0 burst:** `done_o` at T+1, no SRAM access, no stream output.
- **`rd_ready_i` low:** at most 2 words are buffered and issue stalls; `mem_req_o` stays low until a slot frees. No word is lost or duplicated.
- **Write:** single cycle; `wr_gnt_o` is combinational in IDLE; SRAM updates at the next clock edge.
- **Reset mid-burst:** immediately returns to IDLE with FIFO flushed. No `done_o` for the aborted burst. A late `mem_rdata_i` is ignored.

## Structure
- State enum `weightmem_ctrl_state_e` (IDLE, READ, DRAIN) goes in a new `enums_weightmem_ctrl` package.
- Width parameters are taken from `cutie_params`.
- Sub-module `weightmem_rd_fifo`: 2-entry FIFO carrying data+last, with push, pop, count, async active-high reset.

## Test plan
- After reset: all outputs match the reset values above. Write 0xA5..A5 to address 3 → `wr_gnt_o` for 1 cycle, mem req=1 we=1 addr=3.
- Burst addr=0, len=4, ready high → `mem_req_o` at T+1..T+4 with addresses 0..3. Words stream at T+3..T+6 with `rd_last_o` on the 4th. `done_o` at T+7.
- Same burst, `rd_ready_i` toggled 1-0-0-1 → data order 0,1,2,3 preserved. FIFO count never exceeds 2; issue stalls while full.
- Burst addr=NUM_WORDS-2, len=3 → addresses NUM_WORDS-2, NUM_WORDS-1, 0.
- `wr_req_i` and `burst_valid_i` both high in IDLE → write granted, `burst_ready_o` = 0. Burst accepted on the first cycle `wr_req_i` is low. `wr_req_i` during READ → `wr_gnt_o` stays 0.
- `rst_i` pulsed during READ of len=8 → outputs return to reset values asynchronously, no `done_o`. A new len=1 burst then completes normally.
